// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the bomb-defuse game.
// Sequences scramble requests, the countdown, set-button judging,
// strikes, rounds, checklight and the win/lose flags.
// Ports: CLK, RST (async, active-low), game_enable, start_btn, set_btn,
//   match, scramble_ack in; scramble_req, period, time_left, round,
//   strikes, checklight, game_won, game_lost out.
// Optional: define PENALTY_EN to take PENALTY ticks off on a wrong press.
module game_round_ctrl #(
  parameter int          ROUNDS      = 4,
  parameter int          STRIKES_MAX = 3,
  parameter int          TICK_DIV    = 50000,
  parameter logic [7:0]  PERIOD_INIT = 8'd200,
  parameter logic [7:0]  PERIOD_STEP = 8'd20,
  parameter logic [7:0]  PERIOD_MIN  = 8'd40,
  parameter logic [15:0] RESULT_CYC  = 16'd1000
`ifdef PENALTY_EN
  ,
  parameter logic [7:0]  PENALTY     = 8'd10
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       game_enable,
  input  logic       start_btn,
  input  logic       set_btn,
  input  logic       match,
  input  logic       scramble_ack,
  output logic       scramble_req,
  output logic [7:0] period,
  output logic [7:0] time_left,
  output logic [2:0] round,
  output logic [1:0] strikes,
  output logic [1:0] checklight,
  output logic       game_won,
  output logic       game_lost
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);
  localparam logic [1:0] STRIKE_LIM = 2'(STRIKES_MAX);
  localparam logic [8:0] STEP_FLOOR =
    {1'b0, PERIOD_MIN} + {1'b0, PERIOD_STEP};

  localparam logic [1:0] CL_NONE    = 2'b00;
  localparam logic [1:0] CL_OK      = 2'b01;
  localparam logic [1:0] CL_WRONG   = 2'b10;
  localparam logic [1:0] CL_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SCRAMBLE,
    COUNT,
    RESULT,
    WON,
    LOST
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          start_q;
  logic          set_q;
  logic          req_q;
  logic          req_nxt;
  logic [7:0]    period_nxt;
  logic [7:0]    time_left_nxt;
  logic [2:0]    round_nxt;
  logic [1:0]    strikes_nxt;
  logic [1:0]    cl_nxt;
  logic          won_nxt;
  logic          lost_nxt;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic [15:0]   res_cnt;
  logic [15:0]   res_nxt;
  // 1: RESULT returns to COUNT, 0: RESULT returns to SCRAMBLE
  logic          resume_cnt;
  logic          resume_nxt;
  logic          go_idle;

  logic          start_edge;
  logic          set_edge;
  logic          tick_wrap;
  logic [1:0]    strikes_inc;
  logic [7:0]    period_dec;
  logic [7:0]    time_pen;

  assign start_edge  = start_btn & ~start_q;
  assign set_edge    = set_btn & ~set_q;
  assign tick_wrap   = tick_cnt == TICK_LAST;
  assign strikes_inc = (strikes == STRIKE_LIM) ? strikes
                                               : strikes + 2'd1;
  // compare in 9 bits so the floor test cannot underflow
  assign period_dec  = ({1'b0, period} >= STEP_FLOOR)
                       ? period - PERIOD_STEP : PERIOD_MIN;

`ifdef PENALTY_EN
  assign time_pen = (time_left > PENALTY) ? time_left - PENALTY
                                          : 8'd0;
`else
  assign time_pen = time_left;
`endif

  // an abort must drop the request without waiting for a clock
  assign scramble_req = req_q & game_enable;

  always_comb begin
    state_nxt     = state;
    req_nxt       = req_q;
    period_nxt    = period;
    time_left_nxt = time_left;
    round_nxt     = round;
    strikes_nxt   = strikes;
    cl_nxt        = checklight;
    won_nxt       = game_won;
    lost_nxt      = game_lost;
    tick_nxt      = tick_cnt;
    res_nxt       = res_cnt;
    resume_nxt    = resume_cnt;
    go_idle       = 1'b0;

    if (!game_enable) begin
      go_idle = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state_nxt   = SCRAMBLE;
            round_nxt   = 3'd0;
            strikes_nxt = 2'd0;
          end else begin
            go_idle = 1'b1;
          end
        end

        SCRAMBLE: begin
          if (!req_q) begin
            req_nxt = 1'b1;
          end else if (scramble_ack) begin
            req_nxt       = 1'b0;
            time_left_nxt = period;
            tick_nxt      = '0;
            state_nxt     = COUNT;
          end
        end

        COUNT: begin
          tick_nxt = tick_wrap ? '0 : tick_cnt + 1'b1;
          if (set_edge) begin
            // the press wins over a same-cycle wrap; the
            // counter freezes so a wrong press resumes in place
            tick_nxt = tick_cnt;
            if (match) begin
              cl_nxt = CL_OK;
              if (round == LAST_ROUND) begin
                state_nxt = WON;
                won_nxt   = 1'b1;
              end else begin
                round_nxt  = round + 3'd1;
                period_nxt = period_dec;
                state_nxt  = RESULT;
                res_nxt    = 16'd0;
                resume_nxt = 1'b0;
              end
            end else begin
              strikes_nxt   = strikes_inc;
              cl_nxt        = CL_WRONG;
              time_left_nxt = time_pen;
              if (strikes_inc == STRIKE_LIM) begin
                state_nxt = LOST;
                lost_nxt  = 1'b1;
              end else begin
                state_nxt  = RESULT;
                res_nxt    = 16'd0;
                resume_nxt = 1'b1;
              end
            end
          end else if (tick_wrap) begin
            if (time_left != 8'd0) begin
              time_left_nxt = time_left - 8'd1;
            end else begin
              strikes_nxt = strikes_inc;
              cl_nxt      = CL_TIMEOUT;
              if (strikes_inc == STRIKE_LIM) begin
                state_nxt = LOST;
                lost_nxt  = 1'b1;
              end else begin
                state_nxt  = RESULT;
                res_nxt    = 16'd0;
                resume_nxt = 1'b0;
              end
            end
          end
        end

        RESULT: begin
          if (res_cnt >= RESULT_CYC - 16'd1) begin
            cl_nxt    = CL_NONE;
            state_nxt = resume_cnt ? COUNT : SCRAMBLE;
          end else begin
            res_nxt = res_cnt + 16'd1;
          end
        end

        WON: begin
          won_nxt = 1'b1;
          cl_nxt  = CL_OK;
          if (start_edge) go_idle = 1'b1;
        end

        LOST: begin
          lost_nxt = 1'b1;
          cl_nxt   = CL_WRONG;
          if (start_edge) go_idle = 1'b1;
        end

        default: go_idle = 1'b1;
      endcase
    end

    if (go_idle) begin
      state_nxt     = IDLE;
      req_nxt       = 1'b0;
      period_nxt    = PERIOD_INIT;
      time_left_nxt = 8'd0;
      round_nxt     = 3'd0;
      strikes_nxt   = 2'd0;
      cl_nxt        = CL_NONE;
      won_nxt       = 1'b0;
      lost_nxt      = 1'b0;
      tick_nxt      = '0;
      res_nxt       = 16'd0;
      resume_nxt    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      set_q      <= 1'b0;
      req_q      <= 1'b0;
      period     <= PERIOD_INIT;
      time_left  <= 8'd0;
      round      <= 3'd0;
      strikes    <= 2'd0;
      checklight <= CL_NONE;
      game_won   <= 1'b0;
      game_lost  <= 1'b0;
      tick_cnt   <= '0;
      res_cnt    <= 16'd0;
      resume_cnt <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_q    <= start_btn;
      set_q      <= set_btn;
      req_q      <= req_nxt;
      period     <= period_nxt;
      time_left  <= time_left_nxt;
      round      <= round_nxt;
      strikes    <= strikes_nxt;
      checklight <= cl_nxt;
      game_won   <= won_nxt;
      game_lost  <= lost_nxt;
      tick_cnt   <= tick_nxt;
      res_cnt    <= res_nxt;
      resume_cnt <= resume_nxt;
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: scoreboard bench for game_round_ctrl.
// Two instances: rounds=2 for most paths, rounds=4 for the period floor.
module tb_game_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en4 = 1'b0;
  logic start_btn = 1'b0;
  logic set_btn = 1'b0;
  logic match = 1'b0;
  logic ack = 1'b0;

  logic       req, won, lost;
  logic [7:0] period, tl;
  logic [2:0] round;
  logic [1:0] strikes, cl;

  logic       req4, won4, lost4;
  logic [7:0] period4, tl4;
  logic [2:0] round4;
  logic [1:0] strikes4, cl4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .ROUNDS(2), .STRIKES_MAX(2), .TICK_DIV(4),
    .PERIOD_INIT(8'd10), .PERIOD_STEP(8'd3), .PERIOD_MIN(8'd6),
    .RESULT_CYC(16'd3)
  ) dut (
    .CLK(clk), .RST(rst_n), .game_enable(en),
    .start_btn(start_btn), .set_btn(set_btn), .match(match),
    .scramble_ack(ack), .scramble_req(req), .period(period),
    .time_left(tl), .round(round), .strikes(strikes),
    .checklight(cl), .game_won(won), .game_lost(lost)
  );

  game_round_ctrl #(
    .ROUNDS(4), .STRIKES_MAX(2), .TICK_DIV(4),
    .PERIOD_INIT(8'd10), .PERIOD_STEP(8'd3), .PERIOD_MIN(8'd6),
    .RESULT_CYC(16'd3)
  ) dut4 (
    .CLK(clk), .RST(rst_n), .game_enable(en4),
    .start_btn(start_btn), .set_btn(set_btn), .match(match),
    .scramble_ack(ack), .scramble_req(req4), .period(period4),
    .time_left(tl4), .round(round4), .strikes(strikes4),
    .checklight(cl4), .game_won(won4), .game_lost(lost4)
  );

  // kind 0: scramble request rises, 1: result shown, 2: game over
  typedef struct {
    int         kind;
    logic [1:0] cl;
    logic [1:0] strikes;
    logic [2:0] round;
    logic [7:0] period;
    logic [7:0] tl;
    logic       won;
    logic       lost;
  } exp_t;

  exp_t q[$];
  int   q4[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic void push(input int kind, input logic [1:0] c,
                               input logic [1:0] s,
                               input logic [2:0] r,
                               input logic [7:0] p,
                               input logic [7:0] t,
                               input logic w, input logic l);
    exp_t e;
    e.kind = kind; e.cl = c; e.strikes = s; e.round = r;
    e.period = p; e.tl = t; e.won = w; e.lost = l;
    q.push_back(e);
  endfunction

  initial begin : mon
    logic pr_req, pr_cl, pr_end, hold_act, steady_pend;
    logic [1:0] steady_cl;
    int hold_n;
    exp_t e;
    pr_req = 0; pr_cl = 0; pr_end = 0;
    hold_act = 0; steady_pend = 0; steady_cl = 0; hold_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pr_req = 0; pr_cl = 0; pr_end = 0;
        hold_act = 0; steady_pend = 0;
      end else begin
        if (steady_pend) begin
          chk("end_steady_cl", cl, steady_cl);
          steady_pend = 0;
        end
        if (hold_act) begin
          if (cl != 2'b00) hold_n++;
          else begin
            chk("result_hold_cycles", hold_n, 3);
            hold_act = 0;
          end
        end
        if (req && !pr_req) begin
          if (q.size() == 0) chk("unexpected_scramble", 1, 0);
          else begin
            e = q.pop_front();
            chk("scr_kind", 0, e.kind);
            chk("scr_round", round, e.round);
            chk("scr_period", period, e.period);
            chk("scr_strikes", strikes, e.strikes);
          end
        end
        if (cl != 2'b00 && !pr_cl && !won && !lost) begin
          if (q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = q.pop_front();
            chk("res_kind", 1, e.kind);
            chk("res_checklight", cl, e.cl);
            chk("res_strikes", strikes, e.strikes);
            chk("res_round", round, e.round);
            chk("res_period", period, e.period);
            chk("res_time_left", tl, e.tl);
            hold_act = 1; hold_n = 1;
          end
        end
        if ((won || lost) && !pr_end) begin
          if (q.size() == 0) chk("unexpected_end", 1, 0);
          else begin
            e = q.pop_front();
            chk("end_kind", 2, e.kind);
            chk("end_won", won, e.won);
            chk("end_lost", lost, e.lost);
            chk("end_checklight", cl, e.cl);
            chk("end_strikes", strikes, e.strikes);
            chk("end_round", round, e.round);
            chk("end_period", period, e.period);
            steady_pend = 1;
            steady_cl = e.won ? 2'b01 : 2'b10;
          end
        end
        pr_req = req;
        pr_cl  = cl != 2'b00;
        pr_end = won || lost;
      end
    end
  end

  initial begin : mon4
    logic pr;
    int v;
    pr = 0;
    forever begin
      @(negedge clk);
      if (req4 && !pr) begin
        if (q4.size() == 0) chk("unexpected_scramble4", 1, 0);
        else begin
          v = q4.pop_front();
          chk("floor_round", round4, v / 256);
          chk("floor_period", period4, v % 256);
        end
      end
      pr = req4;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(1);
  endtask

  task automatic press_set(input logic m);
    match = m;
    set_btn = 1'b1;
    step(1);
    set_btn = 1'b0;
    step(1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic wait_req(input bit four, input int lim);
    int n = 0;
    while (((four ? req4 : req) == 1'b0) && n < lim) begin
      step(1);
      n++;
    end
    chk("wait_scramble_req", int'(four ? req4 : req), 1);
  endtask

  task automatic wait_end(input int lim);
    int n = 0;
    while (!(won || lost) && n < lim) begin
      step(1);
      n++;
    end
    chk("wait_game_end", int'(won || lost), 1);
  endtask

  initial begin : stim
    logic [7:0] wrong_tl;
`ifdef PENALTY_EN
    wrong_tl = 8'd0;
`else
    wrong_tl = 8'd8;
`endif
    // reset values
    step(3);
    chk("rst_period", period, 10);
    chk("rst_time_left", tl, 0);
    chk("rst_req", req, 0);
    chk("rst_round", round, 0);
    chk("rst_strikes", strikes, 0);
    chk("rst_checklight", cl, 0);
    chk("rst_won_lost", {won, lost}, 0);
    rst_n = 1'b1;
    step(2);

    // win path
    en = 1'b1;
    push(0, 2'b00, 2'd0, 3'd0, 8'd10, 8'd0, 0, 0);
    press_start();
    wait_req(0, 10);
    do_ack();
    chk("ack_time_left", tl, 10);
    chk("ack_req_low", req, 0);
    push(1, 2'b01, 2'd0, 3'd1, 8'd7, 8'd10, 0, 0);
    push(0, 2'b00, 2'd0, 3'd1, 8'd7, 8'd0, 0, 0);
    press_set(1'b1);
    wait_req(0, 20);
    do_ack();
    push(2, 2'b01, 2'd0, 3'd1, 8'd7, 8'd0, 1, 0);
    press_set(1'b1);
    wait_end(10);
    step(3);
    chk("won_held", won, 1);
    press_start();
    chk("won_cleared", won, 0);
    chk("idle_period", period, 10);

    // wrong press at time_left 8, then timeout loss
    push(0, 2'b00, 2'd0, 3'd0, 8'd10, 8'd0, 0, 0);
    press_start();
    wait_req(0, 10);
    do_ack();
    step(8);
    push(1, 2'b10, 2'd1, 3'd0, 8'd10, wrong_tl, 0, 0);
    push(2, 2'b11, 2'd2, 3'd0, 8'd10, 8'd0, 0, 1);
    press_set(1'b0);
    wait_end(80);
    step(3);
    chk("lost_held", lost, 1);
    press_start();
    chk("lost_cleared", lost, 0);

    // match on the wrap cycle with time_left 0
    push(0, 2'b00, 2'd0, 3'd0, 8'd10, 8'd0, 0, 0);
    press_start();
    wait_req(0, 10);
    do_ack();
    step(43);
    push(1, 2'b01, 2'd0, 3'd1, 8'd7, 8'd0, 0, 0);
    push(0, 2'b00, 2'd0, 3'd1, 8'd7, 8'd0, 0, 0);
    press_set(1'b1);
    wait_req(0, 20);
    step(2);
    en = 1'b0;
    step(2);

    // abort during scramble, late ack
    en = 1'b1;
    push(0, 2'b00, 2'd0, 3'd0, 8'd10, 8'd0, 0, 0);
    press_start();
    wait_req(0, 10);
    step(1);
    en = 1'b0;
    #1;
    chk("abort_req_drop", req, 0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    en = 1'b1;
    step(5);
    chk("abort_no_req", req, 0);
    chk("abort_time_left", tl, 0);
    chk("abort_period", period, 10);

    // asynchronous reset mid-game
    push(0, 2'b00, 2'd0, 3'd0, 8'd10, 8'd0, 0, 0);
    press_start();
    wait_req(0, 10);
    do_ack();
    step(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_time_left", tl, 0);
    chk("midrst_period", period, 10);
    chk("midrst_req", req, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // period floor on the four-round instance
    en = 1'b0;
    en4 = 1'b1;
    q4.push_back(0 * 256 + 10);
    q4.push_back(1 * 256 + 7);
    q4.push_back(2 * 256 + 6);
    q4.push_back(3 * 256 + 6);
    press_start();
    for (int i = 0; i < 3; i++) begin
      wait_req(1, 20);
      do_ack();
      press_set(1'b1);
    end
    wait_req(1, 20);
    step(2);
    en4 = 1'b0;
    step(2);
    chk("floor_abort_req", req4, 0);
    chk("floor_abort_period", period4, 10);
    chk("floor_abort_tl", tl4, 0);
    chk("floor_abort_rs", {round4, strikes4, cl4}, 0);
    chk("floor_abort_wl", {won4, lost4}, 0);

    step(2);
    chk("queue_empty", q.size(), 0);
    chk("queue4_empty", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
